// File: rtl/mmio_uart_hub.sv
// mmio_uart_hub: CHANNELS buffered 8N1 UART receivers exposed as DATA/STATUS words on the CPU bus
// Ports: clock/reset (sync, active-high); rx[CHANNELS] serial inputs, idle high;
//        address/read_enable/write_enable/write_data CPU bus; hit decodes BASE_ADDR..BASE_ADDR+2*CHANNELS-1;
//        read_data registered read result; irq interrupt request.
// Build option: define MMIO_UART_HUB_IRQ_EN to generate a registered irq, otherwise irq is tied low.
module mmio_uart_hub #(
   parameter int          CHANNELS   = 2,
   parameter int          CLK_HZ     = 50000000,
   parameter int          BAUD       = 9600,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] BASE_ADDR  = 16'hFF00
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] rx,
   input  logic [15:0]         address,
   input  logic                read_enable,
   input  logic                write_enable,
   input  logic [15:0]         write_data,
   output logic                hit,
   output logic [15:0]         read_data,
   output logic                irq
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int DW  = $clog2(DIV + 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   logic [15:0] off;
   logic [7:0]  head [CHANNELS];
   logic [15:0] stat [CHANNELS];
   logic [15:0] rd_mux;
   logic        unused_bits;
   // subtraction wraps addresses below BASE_ADDR to large offsets, so one compare decodes the window
   assign off         = address - BASE_ADDR;
   assign hit         = off < 16'(2 * CHANNELS);
   assign unused_bits = ^write_data[13:0];
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      rx_state_t     st, st_n;
      logic [1:0]    sync;
      logic [DW-1:0] cnt;
      logic [2:0]    idx;
      logic [7:0]    shreg;
      logic [7:0]    mem [FIFO_DEPTH];
      logic [AW-1:0] wp, rp;
      logic [CW-1:0] count;
      logic          ovr, frm, tick, sel, pop, full, push_ok, clr;
      logic          ld_half, ld_full, shift, push, ferr;
      assign tick    = cnt == '0;
      assign sel     = hit && off[2:1] == 2'(c);
      assign pop     = read_enable && sel && !off[0] && count != '0;
      assign clr     = write_enable && sel && off[0];
      assign full    = count == CW'(FIFO_DEPTH);
      // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
      assign push_ok = push && (!full || pop);
      always_comb begin
         st_n    = st;
         ld_half = 1'b0;
         ld_full = 1'b0;
         shift   = 1'b0;
         push    = 1'b0;
         ferr    = 1'b0;
         case (st)
            IDLE: begin
               ld_half = !sync[1];
               st_n    = sync[1] ? IDLE : START;
            end
            START: if (tick) begin
               ld_full = !sync[1];
               st_n    = sync[1] ? IDLE : DATA;
            end
            DATA: if (tick) begin
               shift   = 1'b1;
               ld_full = 1'b1;
               st_n    = idx == 3'd7 ? STOP : DATA;
            end
            default: if (tick) begin
               push = sync[1];
               ferr = !sync[1];
               st_n = IDLE;
            end
         endcase
      end
      always_ff @(posedge clock) begin
         if (reset) begin
            st    <= IDLE;
            sync  <= 2'b11;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovr   <= 1'b0;
            frm   <= 1'b0;
         end else begin
            st    <= st_n;
            sync  <= {sync[0], rx[c]};
            cnt   <= ld_half ? DW'(DIV / 2 - 1) : ld_full ? DW'(DIV - 1) : tick ? cnt : cnt - DW'(1);
            idx   <= st != DATA ? 3'd0 : shift ? idx + 3'd1 : idx;
            shreg <= shift ? {sync[1], shreg[7:1]} : shreg;
            wp    <= wp + AW'(push_ok);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push_ok) - CW'(pop);
            ovr   <= (push && full && !pop) || (ovr && !(clr && write_data[15]));
            frm   <= ferr || (frm && !(clr && write_data[14]));
         end
      end
      always_ff @(posedge clock)
         if (push_ok) mem[wp] <= shreg;
      assign head[c] = count != '0 ? mem[rp] : 8'h00;
      assign stat[c] = {ovr, frm, count != '0, 6'b0, 7'(count)};
   end
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (hit && off[2:1] == 2'(i)) rd_mux = off[0] ? stat[i] : {8'h00, head[i]};
   end
   always_ff @(posedge clock) begin
      if (reset) read_data <= '0;
      else if (read_enable) read_data <= rd_mux;
   end
`ifdef MMIO_UART_HUB_IRQ_EN
   logic irq_n;
   always_comb begin
      irq_n = 1'b0;
      for (int i = 0; i < CHANNELS; i++) irq_n = irq_n | (|stat[i][15:13]);
   end
   always_ff @(posedge clock) begin
      if (reset) irq <= 1'b0;
      else irq <= irq_n;
   end
`else
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_uart_hub.sv
// tb_mmio_uart_hub: directed and randomized checks of mmio_uart_hub against a queue-based reference model
module tb_mmio_uart_hub;
   localparam int          CH    = 2;
   localparam int          CLK   = 50000000;
   localparam int          BAUD  = 5000000;
   localparam int          DEPTH = 8;
   localparam int          DIV   = CLK / BAUD;
   localparam logic [15:0] BASE  = 16'hFF00;
`ifdef MMIO_UART_HUB_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif
   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] rx = '1;
   logic [15:0]   address = '0;
   logic          read_enable = 1'b0;
   logic          write_enable = 1'b0;
   logic [15:0]   write_data = '0;
   logic          hit;
   logic [15:0]   read_data;
   logic          irq;
   int            tests = 0;
   int            fails = 0;
   logic [7:0]    q0[$];
   logic [7:0]    q1[$];
   logic [1:0]    ovr = '0;
   logic [1:0]    frm = '0;
   logic [15:0]   d;

   mmio_uart_hub #(.CHANNELS(CH), .CLK_HZ(CLK), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset), .rx(rx), .address(address), .read_enable(read_enable),
      .write_enable(write_enable), .write_data(write_data), .hit(hit), .read_data(read_data), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int c);
      return c != 0 ? q1.size() : q0.size();
   endfunction

   function automatic logic [15:0] model_rd(input logic [15:0] a);
      logic [15:0] o = a - BASE;
      int c = int'(o[1]);
      if (o >= 16'(2 * CH)) return 16'h0000;
      if (o[0]) return {ovr[c], frm[c], qsize(c) != 0, 6'b0, 7'(qsize(c))};
      if (qsize(c) == 0) return 16'h0000;
      return {8'h00, c != 0 ? q1[0] : q0[0]};
   endfunction

   task automatic model_pop(input logic [15:0] a);
      logic [15:0] o = a - BASE;
      if (o < 16'(2 * CH) && !o[0] && qsize(int'(o[1])) != 0) begin
         if (o[1]) void'(q1.pop_front());
         else void'(q0.pop_front());
      end
   endtask

   task automatic model_rx(input int c, input logic [7:0] b, input bit stop);
      if (!stop) frm[c] = 1'b1;
      else if (qsize(c) == DEPTH) ovr[c] = 1'b1;
      else if (c != 0) q1.push_back(b);
      else q0.push_back(b);
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      ovr = '0;
      frm = '0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [15:0] r);
      @(negedge clock);
      address = a;
      read_enable = 1'b1;
      @(negedge clock);
      read_enable = 1'b0;
      r = read_data;
   endtask

   task automatic chk(input logic [15:0] a, input logic [15:0] exp, input string tag);
      logic [15:0] r;
      cpu_read(a, r);
      check(tag, r, exp);
      model_pop(a);
   endtask

   task automatic chk_model(input logic [15:0] a, input string tag);
      chk(a, model_rd(a), tag);
   endtask

   task automatic wr_stat(input int c, input logic [15:0] v);
      @(negedge clock);
      address = BASE + 16'(2 * c + 1);
      write_data = v;
      write_enable = 1'b1;
      @(negedge clock);
      write_enable = 1'b0;
      if (v[15]) ovr[c] = 1'b0;
      if (v[14]) frm[c] = 1'b0;
   endtask

   task automatic chk_irq(input string tag);
      logic any = ovr != 0 || frm != 0 || q0.size() != 0 || q1.size() != 0;
      @(negedge clock);
      check(tag, {15'b0, irq}, {15'b0, IRQ && any});
   endtask

   task automatic drive_bits(input logic [CH-1:0] mask, input logic [7:0] b0, input logic [7:0] b1,
                             input bit stop, input int nbits);
      for (int s = 0; s < nbits; s++)
         for (int k = 0; k < DIV; k++) begin
            @(negedge clock);
            for (int i = 0; i < CH; i++) begin
               logic [7:0] b = i != 0 ? b1 : b0;
               rx[i] = !mask[i] ? 1'b1 : s == 0 ? 1'b0 : s == 9 ? stop : b[s-1];
            end
         end
   endtask

   task automatic send(input logic [CH-1:0] mask, input logic [7:0] b0, input logic [7:0] b1, input bit stop);
      drive_bits(mask, b0, b1, stop, 10);
      @(negedge clock);
      rx = '1;
      repeat (2 * DIV) @(negedge clock);
      for (int i = 0; i < CH; i++) if (mask[i]) model_rx(i, i != 0 ? b1 : b0, stop);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_read_data", read_data, 16'h0000);
      check("reset_irq", {15'b0, irq}, 16'h0000);
      address = BASE + 16'd3;
      #1 check("hit_top", {15'b0, hit}, 16'h0001);
      address = BASE + 16'd4;
      #1 check("hit_above", {15'b0, hit}, 16'h0000);
      address = BASE - 16'd1;
      #1 check("hit_below", {15'b0, hit}, 16'h0000);
      chk(BASE + 16'd1, 16'h0000, "reset_stat0");
      chk(BASE + 16'd3, 16'h0000, "reset_stat1");
      // single byte on channel 0
      send(2'b01, 8'hA5, 8'h00, 1'b1);
      chk(BASE + 16'd1, 16'h2001, "a5_stat");
      chk_irq("a5_irq");
      chk(BASE, 16'h00A5, "a5_data");
      repeat (3) @(negedge clock);
      check("read_data_hold", read_data, 16'h00A5);
      chk(BASE + 16'd1, 16'h0000, "a5_stat_after");
      chk_irq("a5_irq_clear");
      chk(BASE + 16'd4, 16'h0000, "out_of_range");
      // overrun on channel 1
      for (int b = 1; b <= 9; b++) send(2'b10, 8'h00, 8'(b), 1'b1);
      chk(BASE + 16'd3, 16'hA008, "ovr_stat");
      for (int b = 1; b <= 8; b++) chk(BASE + 16'd2, 16'(b), "ovr_data");
      chk(BASE + 16'd2, 16'h0000, "ovr_empty_data");
      chk(BASE + 16'd3, 16'h8000, "ovr_flag_sticky");
      wr_stat(1, 16'h8000);
      chk(BASE + 16'd3, 16'h0000, "ovr_cleared");
      // framing error
      send(2'b01, 8'h3C, 8'h00, 1'b0);
      chk(BASE + 16'd1, 16'h4000, "frm_stat");
      chk(BASE, 16'h0000, "frm_data");
      wr_stat(0, 16'h4000);
      chk(BASE + 16'd1, 16'h0000, "frm_cleared");
      // 3-cycle glitch is rejected
      repeat (3) begin @(negedge clock); rx[0] = 1'b0; end
      @(negedge clock);
      rx = '1;
      repeat (2 * DIV) @(negedge clock);
      chk(BASE + 16'd1, 16'h0000, "glitch_stat");
      // simultaneous bytes on both channels
      send(2'b11, 8'h11, 8'h22, 1'b1);
      chk_irq("dual_irq_full");
      chk(BASE, 16'h0011, "dual_data0");
      chk_irq("dual_irq_half");
      chk(BASE + 16'd2, 16'h0022, "dual_data1");
      chk_irq("dual_irq_drained");
      // reset in the middle of a frame
      drive_bits(2'b01, 8'h5A, 8'h00, 1'b1, 5);
      reset = 1'b1;
      rx = '1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      model_reset();
      chk(BASE + 16'd1, 16'h0000, "midreset_stat0");
      chk(BASE + 16'd3, 16'h0000, "midreset_stat1");
      send(2'b01, 8'h5A, 8'h00, 1'b1);
      chk(BASE, 16'h005A, "midreset_data");
      // randomized traffic against the model
      for (int n = 0; n < 30; n++) begin
         int c = $urandom_range(0, 1);
         logic [7:0] b = 8'($urandom);
         bit stop = $urandom_range(0, 7) != 0;
         int op = $urandom_range(0, 3);
         send(c != 0 ? 2'b10 : 2'b01, b, b, stop);
         if (op == 0) chk_model(BASE + 16'(2 * c + 1), "rnd_stat");
         if (op == 1) chk_model(BASE + 16'(2 * c), "rnd_data");
         if (op == 2) begin
            wr_stat(c, {2'($urandom), 14'($urandom)});
            chk_model(BASE + 16'(2 * c + 1), "rnd_clr_stat");
         end
         chk_irq("rnd_irq");
      end
      for (int c = 0; c < CH; c++) begin
         chk_model(BASE + 16'(2 * c + 1), "drain_stat");
         while (qsize(c) != 0) chk_model(BASE + 16'(2 * c), "drain_data");
         chk_model(BASE + 16'(2 * c), "drain_empty");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mmio_uart_hub.md
# mmio_uart_hub

Parametrised multi-channel serial input hub: CHANNELS independent 8N1 UART receivers, each feeding its own receive FIFO, exposed to the CPU as memory-mapped data and status registers. It sits on the CPU memory bus beside the memory/IO block, replacing the single unbuffered receive byte with buffered, error-flagged, per-channel input and an optional interrupt line.

## Interface
Parameters:
- CHANNELS, 2: number of receive channels, 1..4.
- CLK_HZ, 50000000: clock frequency in Hz.
- BAUD, 9600: line rate; DIV = CLK_HZ/BAUD (integer division), DIV >= 4.
- FIFO_DEPTH, 8: entries per channel, power of two, 2..64.
- BASE_ADDR, 16'hFF00: first register word address, aligned to 8.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  CHANNELS  serial inputs, idle high, asynchronous to clock.
- address  in  16  CPU word address.
- read_enable  in  1  CPU read strobe for this cycle's address.
- write_enable  in  1  CPU write strobe.
- write_data  in  16  CPU write data.
- hit  out  1  combinational: address within BASE_ADDR..BASE_ADDR+2*CHANNELS-1.
- read_data  out  16  registered read result.
- irq  out  1  interrupt request (see Configuration).

## Operation
- Register map, per channel c: BASE_ADDR+2c = DATA, BASE_ADDR+2c+1 = STATUS.
- DATA read: returns {8'h00, oldest byte} and pops; if FIFO empty returns 16'h0000, no pop, no flag change.
- STATUS read: bit15 overrun, bit14 framing error, bit13 not-empty, bits[6:0] occupancy count (0..FIFO_DEPTH); other bits 0. No side effects.
- STATUS write: write_data bit15=1 clears overrun, bit14=1 clears framing; other bits ignored. DATA writes ignored. Out-of-range addresses: no effect, read_data 16'h0000.
- Per-channel receiver: rx passes a 2-flop synchronizer; FSM IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on synchronized rx low, load baud counter with DIV/2, go START.
  - START: at counter expiry resample; low -> DATA with counter DIV, bit index 0; high -> IDLE (glitch rejected).
  - DATA: sample every DIV cycles, shift in LSB first; after bit 7 -> STOP.
  - STOP: sample after DIV; high -> push byte; low -> set framing flag, discard byte. Then IDLE.
- Push into full FIFO: byte dropped, overrun set. Pop and push on same cycle with FIFO full: pop served first, push accepted, no overrun. Same cycle with FIFO empty: DATA read returns 0, pushed byte stored.
- Flags are sticky until cleared by STATUS write or reset; set-and-clear on same cycle: set wins.
- FIFO pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits.

## Timing
- read_data valid the cycle after read_enable; holds value until next read_enable; pop takes effect at the strobe edge.
- Write effects visible to a STATUS read issued the following cycle.
- rx to FIFO: byte counted in STATUS 2 (synchronizer) + ~9.5*DIV cycles after start edge.
- Reset values: read_data 0, irq 0, all FIFOs empty, counts 0, flags 0, receivers IDLE, synchronizers 1. Reset mid-frame discards the partial byte; receiver restarts on next falling edge after reset deasserts.

## Configuration
- MMIO_UART_HUB_IRQ_EN defined: irq registered, high the cycle after any channel is not-empty or has a set flag; falls the cycle after the last such condition clears.
- Not defined: irq tied to 0; no irq logic synthesised; register map unchanged.

## Test plan
- CLK_HZ=50000000, BAUD=5000000 (DIV=10): send 8'hA5 on rx[0] -> STATUS(0) = 16'h2001; DATA(0) read returns 16'h00A5; next STATUS = 16'h0000.
- Send 9 bytes 8'h01..8'h09 on rx[1], FIFO_DEPTH=8 -> STATUS(1) = 16'hA008; reads return 01..08; write 16'h8000 to STATUS(1) -> 16'h0000.
- Frame with stop bit low, data 8'h3C -> framing flag set, count 0, DATA read 16'h0000.
- 3-cycle low glitch on rx[0] -> no byte, no flags, receiver IDLE.
- Simultaneous bytes 8'h11 on rx[0], 8'h22 on rx[1] -> each channel's DATA returns its own byte; irq high (IRQ_EN) until both drained, irq 0 when macro undefined.
- Assert reset mid-frame after 4 data bits -> all STATUS 16'h0000; next full frame 8'h5A received correctly.
